// File: rtl/mips_pkg.sv
// Shared encodings for ID-stage branch resolution: branch opcodes, forwarding
// selects, resolver FSM states and small decode helpers.
package mips_pkg;

    typedef enum logic [3:0] {
        BrNone = 4'd0,
        BrBeq  = 4'd1,
        BrBne  = 4'd2,
        BrBlez = 4'd3,
        BrBgtz = 4'd4,
        BrBltz = 4'd5,
        BrBgez = 4'd6,
        BrJr   = 4'd7,
        BrJalr = 4'd8
    } brOpE;

    typedef enum logic [2:0] {
        FwdRf        = 3'd0,
        FwdIdExLink  = 3'd1,
        FwdExMemAlu  = 3'd2,
        FwdExMemLink = 3'd3,
        FwdMemWb     = 3'd4
    } fwdSelE;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StStall    = 2'd1,
        StRedirect = 2'd2
    } brStateE;

    localparam logic [15:0] TakenCntMax = 16'hFFFF;

    // Codes 9-15 decode as "no branch".
    function automatic logic isBranch(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic logic usesRt(input logic [3:0] op);
        return (op == BrBeq) || (op == BrBne);
    endfunction

    function automatic logic isJumpReg(input logic [3:0] op);
        return (op == BrJr) || (op == BrJalr);
    endfunction

    function automatic logic branchTaken(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        logic taken;
        taken = 1'b0;
        case (op)
            BrBeq:        taken = (a == b);
            BrBne:        taken = (a != b);
            BrBlez:       taken = a[31] || (a == 32'h0);
            BrBgtz:       taken = !a[31] && (a != 32'h0);
            BrBltz:       taken = a[31];
            BrBgez:       taken = !a[31];
            BrJr, BrJalr: taken = 1'b1;
            default:      taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Stall cycles needed before a source register value is available in ID.
    // A link write from ID_EX is already forwardable, so it costs nothing.
    function automatic logic [1:0] hazardCost(input logic [4:0] src,
                                              input logic idExWr, input logic idExLoad,
                                              input logic idExLink, input logic [4:0] idExDst,
                                              input logic exMemWr, input logic exMemLoad,
                                              input logic [4:0] exMemDst);
        logic [1:0] cost;
        cost = 2'd0;
        if (src != 5'd0) begin
            if (exMemWr && exMemLoad && (exMemDst == src)) cost = 2'd1;
            // ID_EX cost is always >= the EX_MEM cost, so it overrides.
            if (idExWr && !idExLink && (idExDst == src)) cost = idExLoad ? 2'd2 : 2'd1;
        end
        return cost;
    endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// One branch operand: picks the regfile value or a forwarded pipeline value.
module fwd_operand_mux
    import mips_pkg::*;
(
    input  logic [4:0]  regAddr,
    input  logic [2:0]  fsel,
    input  logic [31:0] rfData,
    input  logic [31:0] idExLink,
    input  logic [31:0] exMemAlu,
    input  logic [31:0] exMemLink,
    input  logic [31:0] memWbWdata,
    output logic [31:0] operand
);

    // r0 is hard-wired to zero whatever the forwarding unit says.
    always_comb begin
        operand = 32'h0;
        if (regAddr != 5'd0) begin
            case (fsel)
                FwdIdExLink:  operand = idExLink;
                FwdExMemAlu:  operand = exMemAlu;
                FwdExMemLink: operand = exMemLink;
                FwdMemWb:     operand = memWbWdata;
                default:      operand = rfData;
            endcase
        end
    end

endmodule

// File: rtl/id_branch_resolve.sv
// ID-stage branch resolver: detects load/ALU hazards on branch operands,
// stalls until they clear, then issues a one-cycle PC redirect.
module id_branch_resolve
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [3:0]  br_op,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [2:0]  rs_fsel,
    input  logic [2:0]  rt_fsel,
    input  logic [31:0] rf_rs_data,
    input  logic [31:0] rf_rt_data,
    input  logic [31:0] id_ex_link,
    input  logic [31:0] ex_mem_alu,
    input  logic [31:0] ex_mem_link,
    input  logic [31:0] mem_wb_wdata,
    input  logic        id_ex_wr,
    input  logic        id_ex_is_load,
    input  logic        id_ex_is_link,
    input  logic [4:0]  id_ex_dst,
    input  logic        ex_mem_wr,
    input  logic        ex_mem_is_load,
    input  logic [4:0]  ex_mem_dst,
    input  logic [31:0] br_target,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_if_id,
    output logic [15:0] taken_cnt
);

    brStateE     stateQ, stateD;
    logic [1:0]  cntQ, cntD;
    logic [31:0] redirectPcQ;
    logic [15:0] takenCntQ;
    logic [31:0] rsVal, rtVal;
    logic [1:0]  rsCost, rtCost, hazCost;
    logic        brValid, taken, enterRedirect, stallRaw;
    logic [31:0] resolvePc;

    fwd_operand_mux uRsMux (
        .regAddr    (id_rs),
        .fsel       (rs_fsel),
        .rfData     (rf_rs_data),
        .idExLink   (id_ex_link),
        .exMemAlu   (ex_mem_alu),
        .exMemLink  (ex_mem_link),
        .memWbWdata (mem_wb_wdata),
        .operand    (rsVal)
    );

    fwd_operand_mux uRtMux (
        .regAddr    (id_rt),
        .fsel       (rt_fsel),
        .rfData     (rf_rt_data),
        .idExLink   (id_ex_link),
        .exMemAlu   (ex_mem_alu),
        .exMemLink  (ex_mem_link),
        .memWbWdata (mem_wb_wdata),
        .operand    (rtVal)
    );

    // Hazard cost is the worst case over the sources this branch actually reads.
    always_comb begin
        brValid   = id_valid && isBranch(br_op);
        rsCost    = hazardCost(id_rs, id_ex_wr, id_ex_is_load, id_ex_is_link, id_ex_dst,
                               ex_mem_wr, ex_mem_is_load, ex_mem_dst);
        rtCost    = usesRt(br_op) ? hazardCost(id_rt, id_ex_wr, id_ex_is_load, id_ex_is_link,
                                               id_ex_dst, ex_mem_wr, ex_mem_is_load,
                                               ex_mem_dst) : 2'd0;
        hazCost   = (rsCost > rtCost) ? rsCost : rtCost;
        taken     = branchTaken(br_op, rsVal, rtVal);
        resolvePc = isJumpReg(br_op) ? rsVal : br_target;
    end

    // Next-state, stall countdown and redirect decision.
    always_comb begin
        stateD        = stateQ;
        cntD          = cntQ;
        stallRaw      = 1'b0;
        enterRedirect = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (brValid) begin
                    if (hazCost != 2'd0) begin
                        stateD   = StStall;
                        cntD     = hazCost - 2'd1;
                        stallRaw = 1'b1;
                    end else if (taken) begin
                        stateD        = StRedirect;
                        enterRedirect = 1'b1;
                    end
                end
            end
            StStall: begin
                if (!id_valid) begin
                    stateD = StIdle;
                    cntD   = 2'd0;
                end else if (cntQ != 2'd0) begin
                    stallRaw = 1'b1;
                    cntD     = cntQ - 2'd1;
                end else if (taken) begin
                    stateD        = StRedirect;
                    enterRedirect = 1'b1;
                end else begin
                    stateD = StIdle;
                end
            end
            // Whatever sits in ID now is being flushed, so it is ignored.
            StRedirect: stateD = StIdle;
            default:    stateD = StIdle;
        endcase
    end

    // FSM and stall counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
            cntQ   <= 2'd0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    // Redirect target and saturating taken-branch count, captured at resolution.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirectPcQ <= 32'h0;
            takenCntQ   <= 16'h0;
        end else if (enterRedirect) begin
            redirectPcQ <= resolvePc;
            if (takenCntQ != TakenCntMax) takenCntQ <= takenCntQ + 16'd1;
        end
    end

    // Stall is combinational, so mask it while reset is asserted.
    always_comb begin
        stall          = stallRaw && rst_n;
        redirect_valid = (stateQ == StRedirect);
        flush_if_id    = (stateQ == StRedirect);
        redirect_pc    = redirectPcQ;
        taken_cnt      = takenCntQ;
    end

endmodule

// File: tb/tb_id_branch_resolve.sv
// Directed bench for id_branch_resolve: table of single-cycle branches plus
// hand-written stall, flush, reset and saturation sequences.
module tb_id_branch_resolve;

    localparam logic [31:0] IdExLinkV  = 32'h0000_0404;
    localparam logic [31:0] ExMemAluV  = 32'h0000_1234;
    localparam logic [31:0] ExMemLinkV = 32'h0000_5678;
    localparam logic [31:0] MemWbV     = 32'h0000_9ABC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  br_op;
    logic [4:0]  id_rs, id_rt;
    logic [2:0]  rs_fsel, rt_fsel;
    logic [31:0] rf_rs_data, rf_rt_data, id_ex_link, ex_mem_alu, ex_mem_link, mem_wb_wdata;
    logic        id_ex_wr, id_ex_is_load, id_ex_is_link;
    logic [4:0]  id_ex_dst;
    logic        ex_mem_wr, ex_mem_is_load;
    logic [4:0]  ex_mem_dst;
    logic [31:0] br_target;
    logic        stall, redirect_valid, flush_if_id;
    logic [31:0] redirect_pc;
    logic [15:0] taken_cnt;

    int nChecks = 0;
    int nFail   = 0;
    logic [31:0] expPc;
    logic [15:0] expCnt;

    always #5 clk = ~clk;

    id_branch_resolve dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .br_op          (br_op),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .rs_fsel        (rs_fsel),
        .rt_fsel        (rt_fsel),
        .rf_rs_data     (rf_rs_data),
        .rf_rt_data     (rf_rt_data),
        .id_ex_link     (id_ex_link),
        .ex_mem_alu     (ex_mem_alu),
        .ex_mem_link    (ex_mem_link),
        .mem_wb_wdata   (mem_wb_wdata),
        .id_ex_wr       (id_ex_wr),
        .id_ex_is_load  (id_ex_is_load),
        .id_ex_is_link  (id_ex_is_link),
        .id_ex_dst      (id_ex_dst),
        .ex_mem_wr      (ex_mem_wr),
        .ex_mem_is_load (ex_mem_is_load),
        .ex_mem_dst     (ex_mem_dst),
        .br_target      (br_target),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .taken_cnt      (taken_cnt)
    );

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [4:0]  rs, rt;
        logic [2:0]  rsSel, rtSel;
        logic [31:0] rsRf, rtRf, target;
        logic [2:0]  idEx;   // {wr, load, link}
        logic [4:0]  idExDst;
        logic [1:0]  exMem;  // {wr, load}
        logic [4:0]  exMemDst;
        logic        expTaken;
        logic [31:0] expPc;
    } vecT;

    vecT vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic addVec(input logic valid, input logic [3:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [2:0] rsSel, input logic [2:0] rtSel,
                          input logic [31:0] rsRf, input logic [31:0] rtRf,
                          input logic [31:0] target, input logic [2:0] idEx,
                          input logic [4:0] idExDst, input logic [1:0] exMem,
                          input logic [4:0] exMemDst, input logic expTaken,
                          input logic [31:0] pc);
        vecT v;
        v = '{valid, op, rs, rt, rsSel, rtSel, rsRf, rtRf, target, idEx, idExDst, exMem,
              exMemDst, expTaken, pc};
        vecs.push_back(v);
    endtask

    task automatic idleInputs();
        id_valid = 1'b0; br_op = 4'd0; id_rs = 5'd0; id_rt = 5'd0;
        rs_fsel = 3'd0; rt_fsel = 3'd0; rf_rs_data = 32'h0; rf_rt_data = 32'h0;
        id_ex_wr = 1'b0; id_ex_is_load = 1'b0; id_ex_is_link = 1'b0; id_ex_dst = 5'd0;
        ex_mem_wr = 1'b0; ex_mem_is_load = 1'b0; ex_mem_dst = 5'd0; br_target = 32'h0;
    endtask

    task automatic branch(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] rsRf, input logic [31:0] rtRf,
                          input logic [31:0] target);
        id_valid = 1'b1; br_op = op; id_rs = rs; id_rt = rt;
        rf_rs_data = rsRf; rf_rt_data = rtRf; br_target = target;
    endtask

    task automatic applyVec(input vecT v);
        id_valid = v.valid; br_op = v.op; id_rs = v.rs; id_rt = v.rt;
        rs_fsel = v.rsSel; rt_fsel = v.rtSel; rf_rs_data = v.rsRf; rf_rt_data = v.rtRf;
        br_target = v.target;
        {id_ex_wr, id_ex_is_load, id_ex_is_link} = v.idEx; id_ex_dst = v.idExDst;
        {ex_mem_wr, ex_mem_is_load} = v.exMem; ex_mem_dst = v.exMemDst;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        id_ex_link = IdExLinkV; ex_mem_alu = ExMemAluV;
        ex_mem_link = ExMemLinkV; mem_wb_wdata = MemWbV;
        idleInputs();
        rst_n = 1'b0;
        expPc = 32'h0; expCnt = 16'h0;

        // valid op rs rt rsSel rtSel rsRf rtRf target idEx idExDst exMem exMemDst taken pc
        addVec(1, 1, 5, 5, 0, 0, 32'd7, 32'd7, 32'h100, 0, 0, 0, 0, 1, 32'h100);
        addVec(1, 1, 5, 6, 0, 0, 32'd7, 32'd8, 32'h104, 0, 0, 0, 0, 0, 32'h0);
        addVec(1, 2, 5, 6, 0, 0, 32'd7, 32'd8, 32'h200, 0, 0, 0, 0, 1, 32'h200);
        addVec(1, 2, 5, 6, 0, 0, 32'd9, 32'd9, 32'h204, 0, 0, 0, 0, 0, 32'h0);
        addVec(1, 3, 4, 0, 0, 0, 32'd0, 32'd0, 32'h300, 0, 0, 0, 0, 1, 32'h300);
        addVec(1, 3, 4, 0, 0, 0, 32'd1, 32'd0, 32'h304, 0, 0, 0, 0, 0, 32'h0);
        addVec(1, 3, 4, 0, 0, 0, 32'h8000_0000, 32'd0, 32'h308, 0, 0, 0, 0, 1, 32'h308);
        addVec(1, 4, 0, 0, 0, 0, 32'd5, 32'd0, 32'h30C, 0, 0, 0, 0, 0, 32'h0);
        addVec(1, 4, 2, 0, 0, 0, 32'd5, 32'd0, 32'h310, 0, 0, 0, 0, 1, 32'h310);
        addVec(1, 4, 2, 0, 0, 0, 32'hFFFF_FFFF, 32'd0, 32'h314, 0, 0, 0, 0, 0, 32'h0);
        addVec(1, 5, 2, 0, 0, 0, 32'hFFFF_FFFF, 32'd0, 32'h318, 0, 0, 0, 0, 1, 32'h318);
        addVec(1, 5, 2, 0, 0, 0, 32'd1, 32'd0, 32'h31C, 0, 0, 0, 0, 0, 32'h0);
        addVec(1, 6, 2, 0, 0, 0, 32'd0, 32'd0, 32'h320, 0, 0, 0, 0, 1, 32'h320);
        addVec(1, 6, 2, 0, 0, 0, 32'h8000_0000, 32'd0, 32'h324, 0, 0, 0, 0, 0, 32'h0);
        addVec(1, 7, 31, 0, 1, 0, 32'hDEAD, 32'd0, 32'h328, 3'b101, 31, 0, 0, 1, IdExLinkV);
        addVec(1, 8, 6, 0, 2, 0, 32'h40, 32'd0, 32'h32C, 0, 0, 0, 0, 1, ExMemAluV);
        addVec(1, 8, 6, 0, 3, 0, 32'h40, 32'd0, 32'h330, 0, 0, 0, 0, 1, ExMemLinkV);
        addVec(1, 8, 6, 0, 4, 0, 32'h40, 32'd0, 32'h334, 0, 0, 0, 0, 1, MemWbV);
        addVec(1, 8, 6, 0, 5, 0, 32'h40, 32'd0, 32'h338, 0, 0, 0, 0, 1, 32'h40);
        addVec(1, 7, 0, 0, 4, 0, 32'h40, 32'd0, 32'h33C, 0, 0, 0, 0, 1, 32'h0);
        addVec(1, 9, 5, 5, 0, 0, 32'd7, 32'd7, 32'h340, 0, 0, 0, 0, 0, 32'h0);
        addVec(0, 1, 5, 5, 0, 0, 32'd7, 32'd7, 32'h344, 0, 0, 0, 0, 0, 32'h0);
        addVec(1, 2, 3, 4, 0, 0, 32'd1, 32'd2, 32'h348, 0, 0, 2'b10, 3, 1, 32'h348);
        addVec(1, 3, 4, 3, 0, 0, 32'd0, 32'd0, 32'h34C, 3'b110, 3, 0, 0, 1, 32'h34C);
        addVec(1, 1, 2, 3, 0, 4, MemWbV, 32'd0, 32'h350, 0, 0, 0, 0, 1, 32'h350);
        addVec(1, 1, 2, 9, 5, 0, 32'h11, 32'h11, 32'h354, 0, 0, 0, 0, 1, 32'h354);
        addVec(1, 0, 5, 0, 0, 0, 32'd0, 32'd0, 32'h358, 3'b110, 5, 0, 0, 0, 32'h0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset stall", 32'(stall), 32'h0);
        check("reset redirect_valid", 32'(redirect_valid), 32'h0);
        check("reset flush", 32'(flush_if_id), 32'h0);
        check("reset redirect_pc", redirect_pc, 32'h0);
        check("reset taken_cnt", 32'(taken_cnt), 32'h0);

        // Table: hazard-free branches resolved in IDLE.
        foreach (vecs[i]) begin
            @(negedge clk);
            applyVec(vecs[i]);
            #1 check($sformatf("vec%0d stall", i), 32'(stall), 32'h0);
            @(negedge clk);
            idleInputs();
            if (vecs[i].expTaken) begin
                expPc  = vecs[i].expPc;
                expCnt = expCnt + 16'd1;
            end
            #1;
            check($sformatf("vec%0d redirect_valid", i), 32'(redirect_valid),
                  32'(vecs[i].expTaken));
            check($sformatf("vec%0d flush", i), 32'(flush_if_id), 32'(vecs[i].expTaken));
            check($sformatf("vec%0d redirect_pc", i), redirect_pc, expPc);
            check($sformatf("vec%0d taken_cnt", i), 32'(taken_cnt), 32'(expCnt));
        end

        // Load in ID_EX feeding bne: two stall cycles, then resolve with MEM_WB data.
        @(negedge clk);
        branch(4'd2, 5'd3, 5'd4, 32'h0, 32'h22, 32'h400);
        id_ex_wr = 1'b1; id_ex_is_load = 1'b1; id_ex_dst = 5'd3;
        #1 check("ldhaz stall c0", 32'(stall), 32'h1);
        @(negedge clk);
        id_ex_wr = 1'b0; id_ex_is_load = 1'b0;
        #1 check("ldhaz stall c1", 32'(stall), 32'h1);
        @(negedge clk);
        rs_fsel = 3'd4; mem_wb_wdata = 32'h11;
        #1 check("ldhaz stall c2", 32'(stall), 32'h0);
        check("ldhaz early redirect", 32'(redirect_valid), 32'h0);
        @(negedge clk);
        idleInputs(); mem_wb_wdata = MemWbV;
        expPc = 32'h400; expCnt = expCnt + 16'd1;
        #1 check("ldhaz redirect_valid", 32'(redirect_valid), 32'h1);
        check("ldhaz redirect_pc", redirect_pc, expPc);
        check("ldhaz taken_cnt", 32'(taken_cnt), 32'(expCnt));

        // EX_MEM load on rt: one stall, then not taken.
        @(negedge clk);
        branch(4'd1, 5'd2, 5'd7, 32'd1, 32'd2, 32'h480);
        ex_mem_wr = 1'b1; ex_mem_is_load = 1'b1; ex_mem_dst = 5'd7;
        #1 check("exhaz stall c0", 32'(stall), 32'h1);
        @(negedge clk);
        ex_mem_wr = 1'b0; ex_mem_is_load = 1'b0;
        #1 check("exhaz stall c1", 32'(stall), 32'h0);
        @(negedge clk);
        idleInputs();
        #1 check("exhaz redirect_valid", 32'(redirect_valid), 32'h0);
        check("exhaz taken_cnt", 32'(taken_cnt), 32'(expCnt));

        // Worst-case cost over rs/rt, then id_valid drops in STALL: no redirect.
        @(negedge clk);
        branch(4'd2, 5'd2, 5'd3, 32'd1, 32'd2, 32'h4C0);
        id_ex_wr = 1'b1; id_ex_is_load = 1'b1; id_ex_dst = 5'd3;
        ex_mem_wr = 1'b1; ex_mem_is_load = 1'b1; ex_mem_dst = 5'd2;
        #1 check("maxhaz stall c0", 32'(stall), 32'h1);
        @(negedge clk);
        #1 check("maxhaz stall c1", 32'(stall), 32'h1);
        @(negedge clk);
        id_valid = 1'b0;
        #1 check("abort stall", 32'(stall), 32'h0);
        @(negedge clk);
        idleInputs();
        #1 check("abort redirect_valid", 32'(redirect_valid), 32'h0);
        check("abort redirect_pc", redirect_pc, expPc);

        // A taken branch presented during REDIRECT is flushed.
        @(negedge clk);
        branch(4'd1, 5'd5, 5'd6, 32'd3, 32'd3, 32'h500);
        @(negedge clk);
        branch(4'd1, 5'd5, 5'd6, 32'd4, 32'd4, 32'h600);
        expPc = 32'h500; expCnt = expCnt + 16'd1;
        #1 check("flush redirect_valid", 32'(redirect_valid), 32'h1);
        check("flush stall", 32'(stall), 32'h0);
        check("flush redirect_pc", redirect_pc, expPc);
        @(negedge clk);
        idleInputs();
        #1 check("flush ignored valid", 32'(redirect_valid), 32'h0);
        check("flush ignored pc", redirect_pc, expPc);
        check("flush ignored cnt", 32'(taken_cnt), 32'(expCnt));

        // Reset during STALL clears everything at once; nothing follows release.
        @(negedge clk);
        branch(4'd2, 5'd3, 5'd4, 32'd1, 32'd2, 32'h700);
        id_ex_wr = 1'b1; id_ex_is_load = 1'b1; id_ex_dst = 5'd3;
        #1 check("rst pre stall", 32'(stall), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        expPc = 32'h0; expCnt = 16'h0;
        #1 check("rst stall", 32'(stall), 32'h0);
        check("rst redirect_valid", 32'(redirect_valid), 32'h0);
        check("rst flush", 32'(flush_if_id), 32'h0);
        check("rst redirect_pc", redirect_pc, 32'h0);
        check("rst taken_cnt", 32'(taken_cnt), 32'h0);
        @(negedge clk);
        idleInputs();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("post-rst redirect c%0d", c), 32'(redirect_valid), 32'h0);
        end

        // Saturation: preload the counter near the top, then two more taken branches.
        @(negedge clk);
        force dut.takenCntQ = 16'hFFFE;
        #1 release dut.takenCntQ;
        expCnt = 16'hFFFE;
        #1 check("sat preload", 32'(taken_cnt), 32'(expCnt));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            branch(4'd7, 5'd31, 5'd0, 32'h800, 32'd0, 32'h0);
            @(negedge clk);
            idleInputs();
            expCnt = 16'hFFFF;
            #1 check($sformatf("sat taken_cnt %0d", k), 32'(taken_cnt), 32'(expCnt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/id_branch_resolve.md
ID_BRANCH_RESOLVE -- requirements
Module: id_branch_resolve

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have rst_n, input, 1; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have id_valid, input, 1, ID stage holds a live instruction.
REQ-004 SHALL have br_op, input, 4: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 jr, 8 jalr; 9-15 treated as none.
REQ-005 SHALL have id_rs, id_rt, input, 5 each, source register numbers of the ID instruction.
REQ-006 SHALL have rs_fsel, rt_fsel, input, 3 each, forwarding select from the ID forwarding units: 0 regfile, 1 ID_EX link, 2 EX_MEM ALU, 3 EX_MEM link, 4 MEM_WB write data; 5-7 treated as 0.
REQ-007 SHALL have rf_rs_data, rf_rt_data, id_ex_link, ex_mem_alu, ex_mem_link, mem_wb_wdata, input, 32 each, candidate operand values.
REQ-008 SHALL have id_ex_wr, id_ex_is_load, id_ex_is_link, input, 1 each, and id_ex_dst, input, 5, ID_EX producer description.
REQ-009 SHALL have ex_mem_wr, ex_mem_is_load, input, 1 each, and ex_mem_dst, input, 5.
REQ-010 SHALL have br_target, input, 32, precomputed PC+4+(offset<<2).
REQ-011 SHALL have stall, output, 1, hold PC and IF_ID, bubble into ID_EX.
REQ-012 SHALL have redirect_valid, output, 1; redirect_pc, output, 32; flush_if_id, output, 1.
REQ-013 SHALL have taken_cnt, output, 16, saturating taken-branch counter.

Function
REQ-014 Operand mux SHALL select rs/rt values per REQ-006; register 0 SHALL always yield 32'h0 regardless of select.
REQ-015 Hazard SHALL exist when id_valid, br_op!=none, a used source (rs always; rt only for beq/bne) is nonzero and either: id_ex_wr & dst match & !id_ex_is_link (cost 2 if id_ex_is_load else 1), or ex_mem_wr & ex_mem_is_load & dst match (cost 1); cost = max over matches.
REQ-016 FSM states SHALL be IDLE, STALL, REDIRECT.
REQ-017 IDLE: hazard with cost N -> STALL, counter loaded N-1, stall=1 this cycle; no hazard and branch taken -> REDIRECT; else stay IDLE.
REQ-018 STALL: stall=1 while counter>0, counter decrements; at counter=0 stall=0, branch resolved with current operands: taken -> REDIRECT, else IDLE.
REQ-019 Conditions: beq a==b; bne a!=b; blez signed a<=0; bgtz signed a>0; bltz a[31]; bgez !a[31]; jr/jalr always taken.
REQ-020 redirect_pc SHALL be registered at resolution: br_target for 1-6, rs operand for 7-8.
REQ-021 REDIRECT SHALL last exactly one cycle: redirect_valid=1, flush_if_id=1, stall=0; next state IDLE; a branch presented during REDIRECT is flushed and SHALL be ignored.
REQ-022 Latency: branch without hazard -> redirect_valid exactly 1 cycle after resolution edge; with hazard cost N -> N+1 cycles.
REQ-023 taken_cnt SHALL increment on each entry to REDIRECT, saturating at 16'hFFFF.
REQ-024 id_valid deasserted in STALL SHALL return FSM to IDLE with no redirect.

Reset
REQ-025 On rst_n low, state=IDLE, counter=0, stall=0, redirect_valid=0, flush_if_id=0, redirect_pc=0, taken_cnt=0, asynchronously.
REQ-026 Reset mid-STALL or mid-REDIRECT SHALL abort with no redirect after release.

Structure
REQ-027 br_op codes, forward-select codes and FSM state encoding SHALL live in shared package mips_pkg.
REQ-028 Operand mux SHALL be sub-module fwd_operand_mux, instantiated twice (rs, rt).

Verification
REQ-029 beq, rs=rt=5, both select 0, rf data 7/7, br_target 0x100 -> redirect_valid=1 next cycle, redirect_pc=0x100, flush_if_id=1, taken_cnt=1.
REQ-030 bne rs=3, ID_EX load writes r3 -> stall high 2 cycles, then resolves with mem_wb_wdata via fsel=4.
REQ-031 jr r31, rs_fsel=1, id_ex_link=0x404 -> no stall, redirect_pc=0x404.
REQ-032 bgtz rs=0 -> never stalls, not taken, redirect_valid stays 0.
REQ-033 taken_cnt preloaded to 0xFFFF by 65535 taken branches, one more -> stays 0xFFFF.
REQ-034 rst_n low during STALL -> all outputs 0 immediately; no redirect after release.
